serial_shift_driver: RTL and testbench

SERIAL_SHIFT_DRIVER -- requirements
Module: serial_shift_driver

---
 rtl/serial_shift_driver.sv | 155 +++++++++++++++
 tb/tb_serial_shift_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_driver.sv
// rtl/serial_shift_driver.sv - parallel-to-serial driver for an external shift/latch register chain
//
// Shifts one DATA_WIDTH-bit word out on sdat, with sclk high for CLK_DIV clk
// cycles and low for CLK_DIV clk cycles per bit. After the last bit it pulses
// latch for CLK_DIV cycles, then pulses done for one cycle.
//
// Ports
//   clk     in   system clock; all state updates on its rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   transfer request; accepted only in IDLE
//   par_in  in   [DATA_WIDTH] word captured when start is accepted
//   busy    out  high in LOW, HIGH and LATCH
//   done    out  one-cycle pulse in the first IDLE cycle after LATCH
//   sclk    out  serial shift clock
//   sdat    out  serial data; stable around the sclk rising edge
//   latch   out  storage-latch strobe
module serial_shift_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int LSB_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] par_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  sdat,
    output logic                  latch
);

    localparam int BW      = $clog2(DATA_WIDTH + 1);
    localparam int PW      = $clog2(CLK_DIV + 1);
    localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic [BW-1:0]         w_bit_cnt_nxt;
    logic [PW-1:0]         r_phase_cnt;
    logic [PW-1:0]         w_phase_cnt_nxt;

    logic r_busy, r_done, r_sclk, r_sdat, r_latch;
    logic w_busy_nxt, w_done_nxt, w_sclk_nxt, w_sdat_nxt, w_latch_nxt;

    logic                  w_phase_end;
    logic [DATA_WIDTH-1:0] w_shift_moved;

    assign w_phase_end = (r_phase_cnt == '0);

    // Move the word one place toward the output end, filling with zero.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_shift_moved = {1'b0, r_shift[DATA_WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_shift_moved = {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_state_nxt = S_LOW;
            S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
            S_HIGH:  if (w_phase_end) w_state_nxt = (r_bit_cnt > BW'(1)) ? S_LOW : S_LATCH;
            S_LATCH: if (w_phase_end) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values. Outputs are computed one cycle ahead
    // from the next state so that every output pin comes straight off a flop.
    always_comb begin
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_phase_cnt_nxt = r_phase_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_shift_nxt     = par_in;
                    w_bit_cnt_nxt   = BW'(DATA_WIDTH);
                    w_phase_cnt_nxt = PW'(CLK_DIV - 1);
                end
            end
            S_HIGH: begin
                w_phase_cnt_nxt = w_phase_end ? PW'(CLK_DIV - 1) : r_phase_cnt - PW'(1);
                if (w_phase_end) begin
                    w_shift_nxt   = w_shift_moved;
                    w_bit_cnt_nxt = r_bit_cnt - BW'(1);
                end
            end
            default: begin
                w_phase_cnt_nxt = w_phase_end ? PW'(CLK_DIV - 1) : r_phase_cnt - PW'(1);
            end
        endcase

        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_sclk_nxt  = (w_state_nxt == S_HIGH);
        w_latch_nxt = (w_state_nxt == S_LATCH);
        w_done_nxt  = (r_state == S_LATCH) && (w_state_nxt == S_IDLE);
        w_sdat_nxt  = ((w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH)) ?
                      w_shift_nxt[OUT_IDX] : 1'b0;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_phase_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sclk      <= 1'b0;
            r_sdat      <= 1'b0;
            r_latch     <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_phase_cnt <= w_phase_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_sclk      <= w_sclk_nxt;
            r_sdat      <= w_sdat_nxt;
            r_latch     <= w_latch_nxt;
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sclk  = r_sclk;
    assign sdat  = r_sdat;
    assign latch = r_latch;

endmodule

// File: tb/tb_serial_shift_driver.sv
// tb/tb_serial_shift_driver.sv - directed self-checking bench for serial_shift_driver
module tb_serial_shift_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // u_main: DATA_WIDTH=8, CLK_DIV=2, MSB first
    logic       st0 = 1'b0;
    logic [7:0] pi0 = '0;
    logic       busy0, done0, sclk0, sdat0, latch0;
    // u_lsb: DATA_WIDTH=8, CLK_DIV=2, LSB first
    logic       st1 = 1'b0;
    logic [7:0] pi1 = '0;
    logic       busy1, done1, sclk1, sdat1, latch1;
    // u_small: DATA_WIDTH=2, CLK_DIV=1
    logic       st2 = 1'b0;
    logic [1:0] pi2 = '0;
    logic       busy2, done2, sclk2, sdat2, latch2;

    serial_shift_driver #(.DATA_WIDTH(8), .CLK_DIV(2), .LSB_FIRST(0)) u_main (
        .clk(clk), .rst_n(rst_n), .start(st0), .par_in(pi0),
        .busy(busy0), .done(done0), .sclk(sclk0), .sdat(sdat0), .latch(latch0));

    serial_shift_driver #(.DATA_WIDTH(8), .CLK_DIV(2), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(st1), .par_in(pi1),
        .busy(busy1), .done(done1), .sclk(sclk1), .sdat(sdat1), .latch(latch1));

    serial_shift_driver #(.DATA_WIDTH(2), .CLK_DIV(1), .LSB_FIRST(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(st2), .par_in(pi2),
        .busy(busy2), .done(done2), .sclk(sclk2), .sdat(sdat2), .latch(latch2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-instance monitors, sampled on the falling edge.
    int          m0_busy = 0, m0_latch = 0, m0_done = 0, m0_rise = 0;
    logic [63:0] m0_bits = '0;
    logic        m0_prev = 1'b0;
    always @(negedge clk) begin
        if (busy0)  m0_busy++;
        if (latch0) m0_latch++;
        if (done0)  m0_done++;
        if (sclk0 && !m0_prev) begin
            m0_rise++;
            m0_bits = {m0_bits[62:0], sdat0};
        end
        m0_prev = sclk0;
    end

    int          m1_rise = 0;
    logic [63:0] m1_bits = '0;
    logic        m1_prev = 1'b0;
    always @(negedge clk) begin
        if (sclk1 && !m1_prev) begin
            m1_rise++;
            m1_bits = {m1_bits[62:0], sdat1};
        end
        m1_prev = sclk1;
    end

    int          m2_busy = 0, m2_latch = 0, m2_rise = 0;
    logic [63:0] m2_bits = '0;
    logic [63:0] m2_sclk_hist = '0;
    logic        m2_prev = 1'b0;
    always @(negedge clk) begin
        if (busy2) begin
            m2_busy++;
            m2_sclk_hist = {m2_sclk_hist[62:0], sclk2};
        end
        if (latch2) m2_latch++;
        if (sclk2 && !m2_prev) begin
            m2_rise++;
            m2_bits = {m2_bits[62:0], sdat2};
        end
        m2_prev = sclk2;
    end

    task automatic wait_done(input int sel, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if ((sel == 0 && done0) || (sel == 1 && done1) || (sel == 2 && done2))
                seen = 1'b1;
        end
        if (!seen) chk("done_timeout", seen, 1'b1);
    endtask

    int s_busy, s_latch, s_done, s_rise;

    task automatic snap0();
        s_busy  = m0_busy;
        s_latch = m0_latch;
        s_done  = m0_done;
        s_rise  = m0_rise;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy0, done0, sclk0, sdat0, latch0}, 5'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {busy0, done0, sclk0, sdat0, latch0}, 5'b0);

        // Single transfer of 8'hA5
        snap0();
        st0 = 1'b1; pi0 = 8'hA5;
        @(negedge clk);
        st0 = 1'b0;
        wait_done(0, 200);
        repeat (3) @(negedge clk);
        chk("a5_bits",  m0_bits[7:0], 8'hA5);
        chk("a5_rises", m0_rise - s_rise, 8);
        chk("a5_busy",  m0_busy - s_busy, 34);
        chk("a5_latch", m0_latch - s_latch, 2);
        chk("a5_done",  m0_done - s_done, 1);
        repeat (10) @(negedge clk);
        chk("a5_quiet", {busy0, m0_done - s_done}, {1'b0, 32'd1});

        // start/par_in toggled during busy are ignored
        snap0();
        st0 = 1'b1; pi0 = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            st0 = i[0];
            pi0 = (i[0]) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        st0 = 1'b0;
        wait_done(0, 200);
        repeat (40) @(negedge clk);
        chk("tog_bits",  m0_bits[7:0], 8'h3C);
        chk("tog_rises", m0_rise - s_rise, 8);
        chk("tog_done",  m0_done - s_done, 1);
        chk("tog_busy",  m0_busy - s_busy, 34);

        // Start held high: back-to-back FF then 00
        snap0();
        st0 = 1'b1; pi0 = 8'hFF;
        @(negedge clk);
        pi0 = 8'h00;
        wait_done(0, 200);
        chk("b2b_idle_in_done", busy0, 1'b0);
        @(negedge clk);
        chk("b2b_second_busy", busy0, 1'b1);
        st0 = 1'b0;
        wait_done(0, 200);
        repeat (3) @(negedge clk);
        chk("b2b_bits",  m0_bits[15:0], 16'hFF00);
        chk("b2b_rises", m0_rise - s_rise, 16);
        chk("b2b_done",  m0_done - s_done, 2);
        chk("b2b_busy",  m0_busy - s_busy, 68);

        // Reset at the 10th busy cycle
        snap0();
        st0 = 1'b1; pi0 = 8'hA5;
        @(negedge clk);
        st0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_was_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy0, done0, sclk0, sdat0, latch0}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("abort_no_latch", m0_latch - s_latch, 0);
        chk("abort_no_done",  m0_done - s_done, 0);
        snap0();
        st0 = 1'b1; pi0 = 8'h96;
        @(negedge clk);
        st0 = 1'b0;
        wait_done(0, 200);
        repeat (3) @(negedge clk);
        chk("fresh_bits", m0_bits[7:0], 8'h96);
        chk("fresh_busy", m0_busy - s_busy, 34);

        // LSB first, 8'h01: 1 then seven 0s
        s_rise = m1_rise;
        st1 = 1'b1; pi1 = 8'h01;
        @(negedge clk);
        st1 = 1'b0;
        wait_done(1, 200);
        repeat (3) @(negedge clk);
        chk("lsb_bits",  m1_bits[7:0], 8'h80);
        chk("lsb_rises", m1_rise - s_rise, 8);

        // DATA_WIDTH=2, CLK_DIV=1, 2'b10
        s_busy  = m2_busy;
        s_latch = m2_latch;
        s_rise  = m2_rise;
        st2 = 1'b1; pi2 = 2'b10;
        @(negedge clk);
        st2 = 1'b0;
        wait_done(2, 50);
        repeat (3) @(negedge clk);
        chk("small_busy",  m2_busy - s_busy, 5);
        chk("small_sclk",  m2_sclk_hist[4:0], 5'b01010);
        chk("small_bits",  {m2_rise - s_rise, m2_bits[1:0]}, {32'd2, 2'b10});
        chk("small_latch", m2_latch - s_latch, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
